servo_scheduler: RTL and testbench

SERVO_SCHEDULER -- requirements
Module: servo_scheduler

---
 rtl/servo_pkg.sv | 23 ++
 rtl/tick_timer.sv | 40 ++++
 rtl/servo_scheduler.sv | 174 +++++++++++++++++
 tb/tb_servo_scheduler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the pan/tilt servo scheduler.
//   state_e  : scheduler FSM states
//   DIR_*    : direction codes used on REQ_* and DIR_* buses
//   req_valid: request qualification against the end stops
package servo_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StMove   = 2'b01,
    StSettle = 2'b10
  } state_e;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;

  // A request counts only if it names a direction whose end stop is not hit.
  // lim[0] guards the positive direction, lim[1] the negative one.
  function automatic logic req_valid(input logic [1:0] req, input logic [1:0] lim);
    return ((req == DIR_POS) && !lim[0]) || ((req == DIR_NEG) && !lim[1]);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// TICK-gated up-counter for the servo scheduler.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tick_i        : 1 MHz strobe, counts only when high
//   clear_i       : synchronous clear (takes priority over counting)
//   term_i        : terminal count
//   done_o        : high in a tick cycle whose count equals term_i
module tick_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             clear_i,
  input  logic [Width-1:0] term_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != {Width{1'b1}})) begin
      // Saturate rather than wrap.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = tick_i && (cnt_q == term_i);

endmodule

// File: rtl/servo_scheduler.sv
// Arbitrates one shared servo power budget between a horizontal and a
// vertical axis. A granted move runs for MOVE_TICKS strobes (or until the
// end stop in the moving direction trips), then holds the axis enabled with
// a stop direction for SETTLE_TICKS strobes before returning to idle.
//   CLK, RST_N     : clock, asynchronous active-low reset
//   TICK           : 1 MHz strobe
//   REQ_H, REQ_V   : per-axis move requests (00 none, 01 pos, 10 neg)
//   LIM_H, LIM_V   : end stops, [0] pos, [1] neg
//   DIR_H/EN_H, DIR_V/EN_V : drive to the per-axis PWM generators
//   GRANT          : one-hot owner, [0] H, [1] V
//   BUSY           : high while moving or settling
module servo_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned MOVE_TICKS   = 2150,
  parameter int unsigned SETTLE_TICKS = 430
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TICK,
  input  logic [1:0] REQ_H,
  input  logic [1:0] REQ_V,
  input  logic [1:0] LIM_H,
  input  logic [1:0] LIM_V,
  output logic [1:0] DIR_H,
  output logic       EN_H,
  output logic [1:0] DIR_V,
  output logic       EN_V,
  output logic [1:0] GRANT,
  output logic       BUSY
);

  localparam int unsigned MaxTicks = (MOVE_TICKS > SETTLE_TICKS) ? MOVE_TICKS : SETTLE_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks) + 1;
  localparam logic [CntW-1:0] MoveTerm   = CntW'(MOVE_TICKS - 1);
  localparam logic [CntW-1:0] SettleTerm = CntW'(SETTLE_TICKS - 1);

  state_e     state_q, state_d;
  logic       axis_q, axis_d;   // 0: H owns the grant, 1: V owns it
  logic [1:0] dir_q, dir_d;     // latched direction of the granted move
  logic       rr_q, rr_d;       // 1: V wins the next contended grant

  logic [1:0] dir_h_q, dir_h_d;
  logic       en_h_q, en_h_d;
  logic [1:0] dir_v_q, dir_v_d;
  logic       en_v_q, en_v_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;

  logic            h_valid, v_valid;
  logic [1:0]      lim_sel;
  logic            lim_hit;
  logic            tmr_clear, tmr_done;
  logic [CntW-1:0] tmr_term;

  assign h_valid = req_valid(REQ_H, LIM_H);
  assign v_valid = req_valid(REQ_V, LIM_V);

  // End stop that guards the latched direction of the moving axis.
  assign lim_sel = axis_q ? LIM_V : LIM_H;
  assign lim_hit = (dir_q == DIR_POS) ? lim_sel[0] : lim_sel[1];

  tick_timer #(
    .Width(CntW)
  ) u_tick_timer (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .tick_i (TICK),
    .clear_i(tmr_clear),
    .term_i (tmr_term),
    .done_o (tmr_done)
  );

  // Next state.
  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    dir_d     = dir_q;
    rr_d      = rr_q;
    tmr_clear = 1'b0;
    tmr_term  = MoveTerm;

    unique case (state_q)
      StIdle: begin
        tmr_clear = 1'b1;
        if (h_valid && (!v_valid || !rr_q)) begin
          state_d = StMove;
          axis_d  = 1'b0;
          dir_d   = REQ_H;
          rr_d    = 1'b1;
        end else if (v_valid) begin
          state_d = StMove;
          axis_d  = 1'b1;
          dir_d   = REQ_V;
          rr_d    = 1'b0;
        end
      end
      StMove: begin
        tmr_term = MoveTerm;
        if (lim_hit || tmr_done) begin
          state_d   = StSettle;
          tmr_clear = 1'b1;
        end
      end
      StSettle: begin
        tmr_term = SettleTerm;
        if (tmr_done) begin
          state_d   = StIdle;
          tmr_clear = 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies change
  // on the same edge as the state itself.
  always_comb begin
    dir_h_d = DIR_STOP;
    en_h_d  = 1'b0;
    dir_v_d = DIR_STOP;
    en_v_d  = 1'b0;
    grant_d = 2'b00;
    busy_d  = 1'b0;
    if (state_d != StIdle) begin
      busy_d  = 1'b1;
      grant_d = axis_d ? 2'b10 : 2'b01;
      if (axis_d) begin
        en_v_d  = 1'b1;
        dir_v_d = (state_d == StMove) ? dir_d : DIR_STOP;
      end else begin
        en_h_d  = 1'b1;
        dir_h_d = (state_d == StMove) ? dir_d : DIR_STOP;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      axis_q  <= 1'b0;
      dir_q   <= DIR_STOP;
      rr_q    <= 1'b0;
      dir_h_q <= DIR_STOP;
      en_h_q  <= 1'b0;
      dir_v_q <= DIR_STOP;
      en_v_q  <= 1'b0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
      dir_q   <= dir_d;
      rr_q    <= rr_d;
      dir_h_q <= dir_h_d;
      en_h_q  <= en_h_d;
      dir_v_q <= dir_v_d;
      en_v_q  <= en_v_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign DIR_H = dir_h_q;
  assign EN_H  = en_h_q;
  assign DIR_V = dir_v_q;
  assign EN_V  = en_v_q;
  assign GRANT = grant_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_servo_scheduler.sv
// Directed bench for servo_scheduler with MOVE_TICKS = 4, SETTLE_TICKS = 2.
module tb_servo_scheduler;

  logic       CLK;
  logic       RST_N;
  logic       TICK;
  logic [1:0] REQ_H, REQ_V, LIM_H, LIM_V;
  logic [1:0] DIR_H, DIR_V, GRANT;
  logic       EN_H, EN_V, BUSY;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_per = 1;

  servo_scheduler #(
    .MOVE_TICKS  (4),
    .SETTLE_TICKS(2)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .TICK (TICK),
    .REQ_H(REQ_H),
    .REQ_V(REQ_V),
    .LIM_H(LIM_H),
    .LIM_V(LIM_V),
    .DIR_H(DIR_H),
    .EN_H (EN_H),
    .DIR_V(DIR_V),
    .EN_V (EN_V),
    .GRANT(GRANT),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {GRANT, BUSY, EN_V, DIR_V, EN_H, DIR_H}
  logic [8:0] obs;
  assign obs = {GRANT, BUSY, EN_V, DIR_V, EN_H, DIR_H};

  function automatic logic [8:0] pk(input logic [1:0] g, input logic b, input logic ev,
                                    input logic [1:0] dv, input logic eh, input logic [1:0] dh);
    return {g, b, ev, dv, eh, dh};
  endfunction

  localparam logic [8:0] Idle    = 9'b00_0_0_00_0_00;
  localparam logic [8:0] HMovePos = 9'b01_1_0_00_1_01;
  localparam logic [8:0] HSettle = 9'b01_1_0_00_1_00;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    TICK = (tick_per != 0) && ((cyc % tick_per) == 0);
  endtask

  initial begin
    int n;
    logic [1:0] g_prev;
    logic [1:0] seq [0:1];
    int ns;

    RST_N = 1'b0;
    TICK  = 1'b0;
    REQ_H = 2'b00;
    REQ_V = 2'b00;
    LIM_H = 2'b00;
    LIM_V = 2'b00;

    // Reset state.
    #12;
    chk("reset_outputs", 32'(obs), 32'(Idle));
    RST_N = 1'b1;

    // Plain H move: 4 cycles moving, 2 settling, then idle.
    tick_per = 1;
    TICK  = 1'b1;
    REQ_H = 2'b01;
    step();
    chk("h_move_c0", 32'(obs), 32'(HMovePos));
    REQ_H = 2'b00;  // withdrawal must be ignored
    step(); chk("h_move_c1", 32'(obs), 32'(HMovePos));
    step(); chk("h_move_c2", 32'(obs), 32'(HMovePos));
    step(); chk("h_move_c3", 32'(obs), 32'(HMovePos));
    step(); chk("h_settle_c0", 32'(obs), 32'(HSettle));
    step(); chk("h_settle_c1", 32'(obs), 32'(HSettle));
    step(); chk("h_idle_after", 32'(obs), 32'(Idle));
    step(); chk("h_idle_stays", 32'(obs), 32'(Idle));

    // V negative move with no contention.
    REQ_V = 2'b10;
    step(); chk("v_move_c0", 32'(obs), 32'(pk(2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00)));
    REQ_V = 2'b00;
    for (int i = 0; i < 5; i++) step();
    chk("v_settle_last", 32'(obs), 32'(pk(2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00)));
    step(); chk("v_idle_after", 32'(obs), 32'(Idle));

    // End stop trips on the 2nd move cycle: settle on the very next edge.
    REQ_H = 2'b01;
    step(); chk("lim_move_c0", 32'(obs), 32'(HMovePos));
    step(); chk("lim_move_c1", 32'(obs), 32'(HMovePos));
    LIM_H = 2'b01;
    step(); chk("lim_abort_settle", 32'(obs), 32'(HSettle));
    step(); chk("lim_settle_c1", 32'(obs), 32'(HSettle));
    step(); chk("lim_idle", 32'(obs), 32'(Idle));
    // Request into an active end stop is never granted.
    step(); chk("lim_blocked_c0", 32'(obs), 32'(Idle));
    step(); chk("lim_blocked_c1", 32'(obs), 32'(Idle));
    step(); chk("lim_blocked_c2", 32'(obs), 32'(Idle));
    // Opposite direction is still allowed against the positive stop.
    REQ_H = 2'b10;
    step(); chk("lim_neg_ok", 32'(obs), 32'(pk(2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10)));
    REQ_H = 2'b00;
    LIM_H = 2'b00;
    for (int i = 0; i < 10 && GRANT != 2'b00; i++) step();
    chk("lim_neg_done", 32'(obs), 32'(Idle));

    // TICK every 3rd cycle: move lasts about 12 cycles.
    tick_per = 3;
    REQ_H = 2'b01;
    step(); chk("slow_move_start", 32'(obs), 32'(HMovePos));
    REQ_H = 2'b00;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (BUSY && DIR_H == 2'b01) n++;
      else break;
    end
    chk("slow_move_len_ok", 32'((n >= 10) && (n <= 14)), 32'd1);
    for (int i = 0; i < 40 && GRANT != 2'b00; i++) step();
    chk("slow_idle", 32'(obs), 32'(Idle));

    // Reset mid-move: outputs drop at once; H wins the first contended grant.
    tick_per = 1;
    REQ_H = 2'b01;
    REQ_V = 2'b10;
    step();
    step();
    chk("pre_reset_busy", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #2;
    chk("async_reset_outputs", 32'(obs), 32'(Idle));
    RST_N = 1'b1;
    step();
    chk("post_reset_grant_h", 32'(obs), 32'(HMovePos));

    // Both requests held: grants alternate H (above), V, H; enables never overlap.
    g_prev = GRANT;
    ns = 0;
    seq[0] = 2'b00;
    seq[1] = 2'b00;
    for (int i = 0; i < 60 && ns < 2; i++) begin
      step();
      chk("no_en_overlap", 32'(EN_H && EN_V), 32'd0);
      if (g_prev == 2'b00 && GRANT != 2'b00) begin
        seq[ns] = GRANT;
        ns++;
      end
      g_prev = GRANT;
    end
    chk("rr_second_grant_v", 32'(seq[0]), 32'(2'b10));
    chk("rr_third_grant_h", 32'(seq[1]), 32'(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
